// File: rtl/ripple_fa_if.sv
// ripple_fa_if: operand/result bundle for the registered ripple-carry adder
interface ripple_fa_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic             in_valid;
  logic [WIDTH-1:0] SUM;
  logic             C_out;
  logic             OVF;
  logic             ZERO;
  logic             out_valid;
  modport master (output A, B, C_in, in_valid, input SUM, C_out, OVF, ZERO, out_valid);
  modport slave  (input A, B, C_in, in_valid, output SUM, C_out, OVF, ZERO, out_valid);
endinterface

// File: rtl/ripple_fa.sv
// ripple_fa: WIDTH-bit ripple-carry adder of full-adder cells with one-cycle registered result
module ripple_fa #(parameter int WIDTH = 4) (
  input logic       clk,
  input logic       rst_n,
  ripple_fa_if.slave bus
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  assign c[0] = bus.C_in;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign s[i]   = bus.A[i] ^ bus.B[i] ^ c[i];
    assign c[i+1] = (bus.A[i] & bus.B[i]) | (bus.A[i] & c[i]) | (bus.B[i] & c[i]);
  end
  // signed overflow is the disagreement between carry into and out of the MSB cell
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.SUM       <= '0;
      bus.C_out     <= 1'b0;
      bus.OVF       <= 1'b0;
      bus.ZERO      <= 1'b1;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.SUM   <= s;
        bus.C_out <= c[WIDTH];
        bus.OVF   <= c[WIDTH] ^ c[WIDTH-1];
        bus.ZERO  <= ~|s;
      end
    end
endmodule

// File: tb/tb_ripple_fa.sv
// tb_ripple_fa: directed checks of the registered 4-bit ripple adder plus an exhaustive sweep
module tb_ripple_fa;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  ripple_fa_if #(.WIDTH(4)) bus ();
  ripple_fa #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic v);
    bus.A = a;
    bus.B = b;
    bus.C_in = ci;
    bus.in_valid = v;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic res(input string tag, input logic [3:0] s, input logic co, input logic ov,
                     input logic z, input logic vld);
    chk({tag, ".sum"}, {4'h0, bus.SUM}, {4'h0, s});
    chk({tag, ".cout"}, {7'h0, bus.C_out}, {7'h0, co});
    chk({tag, ".ovf"}, {7'h0, bus.OVF}, {7'h0, ov});
    chk({tag, ".zero"}, {7'h0, bus.ZERO}, {7'h0, z});
    chk({tag, ".valid"}, {7'h0, bus.out_valid}, {7'h0, vld});
  endtask
  initial begin
    rst_n = 1'b0;
    drive(4'h0, 4'h0, 1'b0, 1'b0);
    step;
    res("reset", 4'h0, 0, 0, 1, 0);
    rst_n = 1'b1;
    drive(4'b0110, 4'b1010, 1'b0, 1'b1);
    step;
    res("wrap_zero", 4'b0000, 1, 0, 1, 1);
    drive(4'b1000, 4'b0100, 1'b0, 1'b1);
    step;
    res("plain", 4'b1100, 0, 0, 0, 1);
    drive(4'b1010, 4'b0101, 1'b0, 1'b1);
    step;
    res("all_ones", 4'b1111, 0, 0, 0, 1);
    drive(4'b1111, 4'b0000, 1'b1, 1'b1);
    step;
    res("cin_ripple", 4'b0000, 1, 0, 1, 1);
    drive(4'b0111, 4'b0001, 1'b0, 1'b1);
    step;
    res("pos_ovf", 4'b1000, 0, 1, 0, 1);
    drive(4'b1000, 4'b1000, 1'b0, 1'b1);
    step;
    res("neg_ovf", 4'b0000, 1, 1, 1, 1);
    drive(4'b0011, 4'b0011, 1'b0, 1'b0);
    step;
    res("hold1", 4'b0000, 1, 1, 1, 0);
    step;
    res("hold2", 4'b0000, 1, 1, 1, 0);
    drive(4'b0101, 4'b0010, 1'b0, 1'b1);
    step;
    res("resume", 4'b0111, 0, 0, 0, 1);
    drive(4'b1001, 4'b1001, 1'b0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    res("async_rst", 4'h0, 0, 0, 1, 0);
    step;
    res("rst_hold", 4'h0, 0, 0, 1, 0);
    rst_n = 1'b1;
    step;
    res("post_rst", 4'b0010, 1, 1, 0, 1);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int ci = 0; ci < 2; ci++) begin
          logic [4:0] t;
          logic [3:0] av, bv;
          av = 4'(a);
          bv = 4'(b);
          t = 5'(a + b + ci);
          drive(av, bv, 1'(ci), 1'b1);
          step;
          chk("sweep.sum", {4'h0, bus.SUM}, {4'h0, t[3:0]});
          chk("sweep.cout", {7'h0, bus.C_out}, {7'h0, t[4]});
          chk("sweep.ovf", {7'h0, bus.OVF}, {7'h0, (av[3] == bv[3]) && (t[3] != av[3])});
          chk("sweep.zero", {7'h0, bus.ZERO}, {7'h0, t[3:0] == 4'h0});
          chk("sweep.valid", {7'h0, bus.out_valid}, 8'h01);
        end
    drive(4'h0, 4'h0, 1'b0, 1'b0);
    step;
    res("idle_end", 4'b1111, 1, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ripple_fa.md
RIPPLE_FA -- requirements
Module: ripple_fa

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, operand and sum width in bits, legal range 1-32.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port A, input, WIDTH bits, unsigned/two's-complement operand A.
REQ-005 The block SHALL have port B, input, WIDTH bits, unsigned/two's-complement operand B.
REQ-006 The block SHALL have port C_in, input, 1 bit, carry into bit 0.
REQ-007 The block SHALL have port in_valid, input, 1 bit, qualifies A/B/C_in this cycle.
REQ-008 The block SHALL have port SUM, output, WIDTH bits, registered sum.
REQ-009 The block SHALL have port C_out, output, 1 bit, registered carry out of the MSB.
REQ-010 The block SHALL have port OVF, output, 1 bit, registered signed overflow flag.
REQ-011 The block SHALL have port ZERO, output, 1 bit, registered flag, high when SUM is all zeros.
REQ-012 The block SHALL have port out_valid, output, 1 bit, high for the cycle in which SUM/C_out/OVF/ZERO hold a new result.

Function
REQ-013 The adder SHALL be a ripple chain of WIDTH one-bit full-adder cells, each with s = a XOR b XOR cin and cout = majority(a, b, cin).
REQ-014 Cell 0 SHALL take C_in; cell i SHALL take the carry of cell i-1; C_out SHALL be the carry of cell WIDTH-1.
REQ-015 {C_out, SUM} SHALL equal A + B + C_in, computed modulo 2^(WIDTH+1) with no truncation of the carry.
REQ-016 OVF SHALL equal the XOR of the carry into cell WIDTH-1 and the carry out of cell WIDTH-1.
REQ-017 ZERO SHALL be 1 exactly when all SUM bits are 0, regardless of C_out.
REQ-018 Latency SHALL be one clock: inputs sampled at edge N with in_valid=1 SHALL appear on outputs after edge N, with out_valid=1 for that one cycle.
REQ-019 When in_valid=0 at an edge, SUM/C_out/OVF/ZERO SHALL hold their previous values and out_valid SHALL be 0 for the next cycle.
REQ-020 Back-to-back in_valid=1 cycles SHALL produce one result per clock with no bubbles; there SHALL be no backpressure.
REQ-021 The combinational path from A/B/C_in to the result registers SHALL contain no feedback and no latches.
REQ-022 The block SHALL contain no state other than the result registers and out_valid.

Reset
REQ-023 Assertion of rst_n=0 SHALL immediately, without waiting for clk, force SUM=0, C_out=0, OVF=0, ZERO=1 and out_valid=0.
REQ-024 While rst_n=0, the block SHALL ignore in_valid and hold all outputs at their reset values.
REQ-025 Reset asserted mid-operation SHALL discard any in-flight result, and the block SHALL NOT produce out_valid for it.
REQ-026 Release of rst_n SHALL take effect synchronously: the first edge with rst_n=1 SHALL sample inputs normally.

Verification
REQ-027 With WIDTH=4, A=0110, B=1010, C_in=0, in_valid=1, the next cycle SHALL give SUM=0000, C_out=1, OVF=0, ZERO=1, out_valid=1.
REQ-028 With A=1000, B=0100, C_in=0, the result SHALL be SUM=1100, C_out=0, OVF=0, ZERO=0.
REQ-029 With A=1010, B=0101, C_in=0, the result SHALL be SUM=1111, C_out=0, OVF=0; then A=1111, B=0000, C_in=1 SHALL give SUM=0000, C_out=1, ZERO=1.
REQ-030 With A=0111, B=0001, C_in=0, the result SHALL be SUM=1000, C_out=0, OVF=1; with A=1000, B=1000, the result SHALL be SUM=0000, C_out=1, OVF=1.
REQ-031 Asserting rst_n=0 between clock edges while a result is pending SHALL clear outputs at once to SUM=0, ZERO=1, out_valid=0; in_valid=0 for two cycles SHALL hold the last SUM with out_valid=0.
REQ-032 An exhaustive 4-bit sweep (512 combinations of A, B and C_in, back-to-back) SHALL match A+B+C_in one cycle later.
